binary_to_tc_pipe: RTL and testbench

//  Binary-to-thermometer-code (TC) encoder for the RNS modulo datapath, mod-M residues.

---
 rtl/binary_to_tc_pipe.sv | 98 +++++++++
 tb/tb_binary_to_tc_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_tc_pipe.sv
// Binary residue to thermometer code encoder, two register stages.
// Full-throughput valid/ready pipe with out-of-range flag and error count.
module binary_to_tc_pipe #(
  parameter int M     = 7,
  parameter int BW    = $clog2(M),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-2:0]     out_tc,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TW = M - 1;

  typedef logic [BW:0]      bx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam bx_t  MV   = bx_t'(M);
  localparam cnt_t CMAX = '1;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic          oor;
  } s1_t;

  s1_t           s1_q;
  logic          s1_valid;
  logic          s2_valid;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic          in_oor;
  logic [TW-1:0] enc;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign accept    = in_valid && s1_adv;
  assign in_oor    = {1'b0, in_bin} >= MV;

  // Out-of-range words encode to zero, matching the decoder's default.
  always_comb begin
    enc = '0;
    for (int i = 0; i < TW; i++) begin
      enc[i] = !s1_q.oor &&
               ({1'b0, s1_q.bin} > bx_t'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.bin <= in_bin;
        s1_q.oor <= in_oor;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_tc   <= '0;
      out_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_tc  <= enc;
        out_err <= s1_q.oor;
      end
    end
  end

  // Clear has priority over a same-cycle counted accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && in_oor &&
                 err_cnt != CMAX) begin
      err_cnt <= err_cnt + cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_binary_to_tc_pipe.sv
// Self-checking bench for binary_to_tc_pipe.
// Directed table, stall/reset sequences, random scoreboard run.
module tb_binary_to_tc_pipe;

  localparam int M  = 7;
  localparam int BW = 3;
  localparam int TW = M - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_bin;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tc;
  logic          out_err;
  logic          err_clr;
  logic [7:0]    err_cnt;

  logic          in_ready2;
  logic          out_valid2;
  logic [TW-1:0] out_tc2;
  logic          out_err2;
  logic [1:0]    err_cnt2;

  binary_to_tc_pipe #(.M(M), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tc(out_tc), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  binary_to_tc_pipe #(.M(M), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_bin(in_bin),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_tc(out_tc2), .out_err(out_err2),
    .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bin;
    logic [TW-1:0] tc;
    logic          err;
  } vec_t;

  typedef struct {
    int            k;
    logic [TW-1:0] tc;
    logic          err;
  } exp_t;

  vec_t tbl[8];
  exp_t q[$];
  int   tests;
  int   fails;
  int   mcnt;
  int   mcnt2;
  bit   last_acc;
  int   sat[4];

  function automatic logic [TW-1:0] ref_tc(int k);
    if (k >= M) return '0;
    return TW'((1 << k) - 1);
  endfunction

  function automatic int decode(logic [TW-1:0] tc);
    int n = 0;
    for (int i = 0; i < TW; i++)
      if (tc[i]) n = i + 1;
    return n;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    bit   acc;
    bit   xfer;
    bit   erdy;
    int   k;
    @(negedge clk);
    erdy = !(q.size() == 2 && !out_ready);
    chk("in_ready", in_ready, erdy);
    chk("in_ready2", in_ready2, erdy);
    chk("err_cnt", err_cnt, mcnt);
    chk("err_cnt2", err_cnt2, mcnt2);
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    if (xfer) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_extra actual=%0h required=none",
                 out_tc);
      end else begin
        e = q.pop_front();
        chk("out_tc", out_tc, e.tc);
        chk("out_err", out_err, e.err);
        chk("out_valid2", out_valid2, 1);
        chk("out_tc2", out_tc2, e.tc);
        chk("out_err2", out_err2, e.err);
        if (!e.err) chk("decode", decode(out_tc), e.k);
      end
    end
    k = int'(in_bin);
    if (acc) begin
      e.k   = k;
      e.tc  = ref_tc(k);
      e.err = (k >= M);
      q.push_back(e);
    end
    if (err_clr) begin
      mcnt  = 0;
      mcnt2 = 0;
    end else if (acc && k >= M) begin
      mcnt  = (mcnt < 255) ? mcnt + 1 : 255;
      mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_valid2", out_valid2, 0);
    chk("rst_tc", out_tc, 0);
    chk("rst_err", out_err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_cnt2", err_cnt2, 0);
    q.delete();
    mcnt     = 0;
    mcnt2    = 0;
    last_acc = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    tests     = 0;
    fails     = 0;
    mcnt      = 0;
    mcnt2     = 0;
    last_acc  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    tbl[0] = '{3'd0, 6'b000000, 1'b0};
    tbl[1] = '{3'd1, 6'b000001, 1'b0};
    tbl[2] = '{3'd2, 6'b000011, 1'b0};
    tbl[3] = '{3'd3, 6'b000111, 1'b0};
    tbl[4] = '{3'd4, 6'b001111, 1'b0};
    tbl[5] = '{3'd5, 6'b011111, 1'b0};
    tbl[6] = '{3'd6, 6'b111111, 1'b0};
    tbl[7] = '{3'd7, 6'b000000, 1'b1};
    sat = '{1, 2, 3, 3};
    #1;
    do_reset();

    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        in_bin   = tbl[j].bin;
      end else begin
        in_valid = 1'b0;
      end
      if (j >= 2) begin
        chk("t1_valid", out_valid, 1);
        chk("t1_tc", out_tc, tbl[j-2].tc);
        chk("t1_err", out_err, tbl[j-2].err);
      end
      tick();
    end

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_clr", err_cnt, 0);
    in_valid = 1'b1;
    in_bin   = 3'd7;
    tick();
    chk("t2_cnt", err_cnt, 1);
    in_bin = 3'd3;
    tick();
    chk("t2_v7", out_valid, 1);
    chk("t2_tc7", out_tc, 0);
    chk("t2_err7", out_err, 1);
    in_valid = 1'b0;
    tick();
    chk("t2_tc3", out_tc, 6'b000111);
    chk("t2_err3", out_err, 0);
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 3'd5;
    tick();
    in_bin = 3'd2;
    tick();
    in_bin = 3'd6;
    chk("t3_stall", in_ready, 0);
    tick();
    tick();
    chk("t3_hold_v", out_valid, 1);
    chk("t3_hold_tc", out_tc, 6'b011111);
    chk("t3_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("t3_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t3_tc2", out_tc, 6'b000011);
    tick();
    chk("t3_tc6", out_tc, 6'b111111);
    tick();
    chk("t3_empty", out_valid, 0);

    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    in_valid = 1'b1;
    in_bin   = 3'd7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_sat", err_cnt2, sat[i]);
    end
    err_clr = 1'b1;
    tick();
    chk("t4_clr2", err_cnt2, 0);
    chk("t4_clr", err_cnt, 0);
    err_clr  = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 3'd7;
    tick();
    in_bin = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("t5_full", out_valid, 1);
    chk("t5_cnt", err_cnt, 1);
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bin    = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("t5_lat1", out_valid, 0);
    tick();
    chk("t5_lat2", out_valid, 1);
    chk("t5_tc", out_tc, 6'b011111);
    tick();

    n = 0;
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bin   = BW'($urandom_range(0, 6));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) n++;
    end
    chk("t6_count", n, 1000);

    for (int c = 0; c < 300; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bin   = BW'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    err_clr   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++)
      tick();
    tick();
    chk("drain", q.size(), 0);
    chk("drain_v", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
